adc_capture_ctrl: RTL and testbench

Trigger-gated sample capture controller sitting directly upstream of the 8192x11 asynchronous prefetch FIFO on its write-clock side. Accepts the 10-bit ADC sample stream, optionally decimates it, and waits for a level-crossing or forced trigger after being armed. It then writes a fixed-length frame of samples into the FIFO as 11-bit words: bit 10 is the frame-start marker, bits 9:0 are sample data.

---
 rtl/capture_pkg.sv | 23 ++
 rtl/capture_trig_detect.sv | 69 ++++++
 rtl/adc_capture_ctrl.sv | 147 ++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Shared types and constants for the ADC capture controller.
//   cap_state_e : controller state encoding (also driven out on the state port)
//   *_DEF       : default widths for sample, frame length and decimation ratio
//   SOF_BIT     : bit index of the frame-start marker in a FIFO word
// -----------------------------------------------------------------------------
package capture_pkg;

   localparam int DATA_W_DEF  = 10;
   localparam int LEN_W_DEF   = 13;
   localparam int DECIM_W_DEF = 8;

   // FIFO word is {sof, sample}, so the marker sits just above the sample
   localparam int SOF_BIT     = DATA_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } cap_state_e;

endpackage

// File: rtl/capture_trig_detect.sv
// -----------------------------------------------------------------------------
// capture_trig_detect
// Level-crossing / forced trigger detector for the capture controller.
// Tracks the previous kept sample while enabled (ARMED) and flags the kept
// sample that crosses the threshold in the selected direction, or the first
// kept sample at/after a force request.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : arm pulse; forgets previous sample and pending force
//   i_en           : controller is ARMED
//   i_kept         : current cycle carries a kept sample
//   i_data         : current sample
//   i_level        : unsigned threshold
//   i_edge         : 0 = rising, 1 = falling
//   i_force        : force-trigger pulse
//   o_trig_hit     : combinational, high for the kept sample that triggers
// -----------------------------------------------------------------------------
module capture_trig_detect
   import capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic              i_kept,
   input  logic [DATA_W-1:0] i_data,
   input  logic [DATA_W-1:0] i_level,
   input  logic              i_edge,
   input  logic              i_force,
   output logic              o_trig_hit
);

   logic [DATA_W-1:0] r_prev;
   logic              r_prev_vld;
   logic              r_force_pend;
   logic              w_rise;
   logic              w_fall;
   logic              w_force;

   assign w_rise  = (r_prev < i_level) && (i_data >= i_level);
   assign w_fall  = (r_prev > i_level) && (i_data <= i_level);
   // a force arriving with a kept sample applies to that sample
   assign w_force = r_force_pend | i_force;

   assign o_trig_hit = i_en && !i_clr && i_kept &&
                       (w_force || (r_prev_vld && (i_edge ? w_fall : w_rise)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev       <= '0;
         r_prev_vld   <= 1'b0;
         r_force_pend <= 1'b0;
      end else if (i_clr) begin
         r_prev_vld   <= 1'b0;
         r_force_pend <= 1'b0;
      end else if (i_en) begin
         if (i_kept) begin
            r_prev       <= i_data;
            r_prev_vld   <= 1'b1;
            r_force_pend <= 1'b0;
         end else if (i_force) begin
            r_force_pend <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_capture_ctrl
// Trigger-gated capture controller feeding the write side of the sample FIFO.
// After arm it waits for a trigger, then writes a fixed number of kept
// samples as {sof, sample}; the first frame word carries sof=1.
// Frame length counts kept samples in time: a sample dropped because the FIFO
// cannot accept it still counts, and sets the sticky overflow flag.
// Build option: CAPTURE_DECIM_EN -- when defined, keep 1 of (decim+1) adc_vld
// strobes; when undefined every strobe is kept and i_decim is ignored.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_adc_data, i_adc_vld : sample stream
//   i_arm                 : start/restart capture (wins over trigger/finish)
//   i_force_trig          : trigger on next kept sample while armed
//   i_trig_level/edge     : threshold and direction (0 rising, 1 falling)
//   i_cap_len, i_decim    : frame length / decimation, latched at arm
//   o_fifo_wr_en/data     : FIFO write strobe and {sof, sample}
//   i_fifo_wr_vld         : FIFO can accept this cycle
//   o_busy, o_done        : state != IDLE, frame-complete pulse
//   o_overflow            : sticky dropped-sample flag, cleared on arm
//   o_state               : IDLE=0, ARMED=1, CAPTURE=2
// -----------------------------------------------------------------------------
module adc_capture_ctrl
   import capture_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int DECIM_W = DECIM_W_DEF
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [DATA_W-1:0]  i_adc_data,
   input  logic               i_adc_vld,
   input  logic               i_arm,
   input  logic               i_force_trig,
   input  logic [DATA_W-1:0]  i_trig_level,
   input  logic               i_trig_edge,
   input  logic [LEN_W-1:0]   i_cap_len,
   input  logic [DECIM_W-1:0] i_decim,
   output logic               o_fifo_wr_en,
   output logic [DATA_W:0]    o_fifo_wr_data,
   input  logic               i_fifo_wr_vld,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overflow,
   output logic [1:0]         o_state
);

   cap_state_e       r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] w_cnt_nxt;
   logic             w_kept;
   logic             w_trig_hit;
   logic             w_frame_smp;
   logic             w_sof;

`ifdef CAPTURE_DECIM_EN
   logic [DECIM_W-1:0] r_decim;
   logic [DECIM_W-1:0] r_dcnt;

   // counts adc_vld strobes, wraps at the latched ratio; phase 0 is kept
   assign w_kept = i_adc_vld && (r_dcnt == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_decim <= '0;
         r_dcnt  <= '0;
      end else if (i_arm) begin
         r_decim <= i_decim;
         r_dcnt  <= '0;
      end else if (i_adc_vld) begin
         r_dcnt  <= (r_dcnt == r_decim) ? '0 : r_dcnt + 1'b1;
      end
   end
`else
   logic w_unused_decim;
   assign w_unused_decim = ^i_decim;
   assign w_kept         = i_adc_vld;
`endif

   capture_trig_detect #(
      .DATA_W (DATA_W)
   ) u_trig (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (i_arm),
      .i_en       (r_state == ST_ARMED),
      .i_kept     (w_kept),
      .i_data     (i_adc_data),
      .i_level    (i_trig_level),
      .i_edge     (i_trig_edge),
      .i_force    (i_force_trig),
      .o_trig_hit (w_trig_hit)
   );

   // a frame sample is the trigger sample (ARMED) or any kept sample in CAPTURE
   assign w_frame_smp = ((r_state == ST_ARMED) && w_trig_hit) ||
                        ((r_state == ST_CAPTURE) && w_kept);
   assign w_sof       = (r_state == ST_ARMED);
   // r_cnt is 0 in ARMED, so the trigger sample makes it 1
   assign w_cnt_nxt   = r_cnt + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_len          <= '0;
         r_cnt          <= '0;
         o_fifo_wr_en   <= 1'b0;
         o_fifo_wr_data <= '0;
         o_done         <= 1'b0;
         o_overflow     <= 1'b0;
      end else begin
         o_fifo_wr_en <= 1'b0;
         o_done       <= 1'b0;
         if (i_arm) begin
            r_len      <= i_cap_len;
            r_cnt      <= '0;
            o_overflow <= 1'b0;
            if (i_cap_len == '0) begin
               r_state <= ST_IDLE;
               o_done  <= 1'b1;
            end else begin
               r_state <= ST_ARMED;
            end
         end else if (w_frame_smp) begin
            if (i_fifo_wr_vld) begin
               o_fifo_wr_en   <= 1'b1;
               o_fifo_wr_data <= {w_sof, i_adc_data};
            end else begin
               o_overflow     <= 1'b1;
            end
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
               r_state <= ST_IDLE;
               o_done  <= 1'b1;
            end else begin
               r_state <= ST_CAPTURE;
            end
         end
      end
   end

   assign o_state = r_state;
   assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
`timescale 1ns/1ps
module tb_adc_capture_ctrl;
   import capture_pkg::*;

   localparam int DW = DATA_W_DEF;
   localparam int LW = LEN_W_DEF;
   localparam int CW = DECIM_W_DEF;

   logic          clk         = 1'b0;
   logic          rst_n       = 1'b0;
   logic [DW-1:0] adc_data    = '0;
   logic          adc_vld     = 1'b0;
   logic          arm         = 1'b0;
   logic          force_trig  = 1'b0;
   logic [DW-1:0] trig_level  = '0;
   logic          trig_edge   = 1'b0;
   logic [LW-1:0] cap_len     = '0;
   logic [CW-1:0] decim       = '0;
   logic          fifo_wr_vld = 1'b1;
   logic          fifo_wr_en;
   logic [DW:0]   fifo_wr_data;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [1:0]    state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   adc_capture_ctrl dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_adc_data     (adc_data),
      .i_adc_vld      (adc_vld),
      .i_arm          (arm),
      .i_force_trig   (force_trig),
      .i_trig_level   (trig_level),
      .i_trig_edge    (trig_edge),
      .i_cap_len      (cap_len),
      .i_decim        (decim),
      .o_fifo_wr_en   (fifo_wr_en),
      .o_fifo_wr_data (fifo_wr_data),
      .i_fifo_wr_vld  (fifo_wr_vld),
      .o_busy         (busy),
      .o_done         (done),
      .o_overflow     (overflow),
      .o_state        (state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // observed write stream and done pulses, tagged with cycle number
   int          wr_cyc_q[$];
   logic [DW:0] wr_dat_q[$];
   int          done_q[$];
   always @(negedge clk) begin
      if (fifo_wr_en) begin
         wr_cyc_q.push_back(cyc);
         wr_dat_q.push_back(fifo_wr_data);
      end
      if (done) done_q.push_back(cyc);
   end

   typedef struct {
      logic [DW-1:0] d;
      bit            v;
      bit            w;
      bit            f;
   } stim_t;
   stim_t sq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d, input bit v, input bit w, input bit f);
      stim_t s;
      s.d = d[DW-1:0];
      s.v = v;
      s.w = w;
      s.f = f;
      sq.push_back(s);
   endtask

   function automatic bit crossed(input int p, input int c, input int lvl, input bit edg);
      return edg ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
   endfunction

   // Arm, play sq, then predict the frame from the list of kept samples:
   // trigger = first kept sample at/after a force or that crosses vs the
   // previous kept one; frame = the next len kept samples from there.
   task automatic run(input string tag, input int len, input int dec, input int lvl,
                      input bit edg, input bit arm_vld);
      int dcyc[$];
      int kidx[$];
      int ecyc[$];
      int edat[$];
      int arm_cyc, nv, fi, t, nf, dec_eff, exp_done, exp_st, k;
      bit exp_ovf;
      cap_len     = LW'(len);
      decim       = CW'(dec);
      trig_level  = DW'(lvl);
      trig_edge   = edg;
      arm         = 1'b1;
      adc_vld     = arm_vld;
      force_trig  = 1'b0;
      fifo_wr_vld = 1'b1;
      wr_cyc_q.delete();
      wr_dat_q.delete();
      done_q.delete();
      arm_cyc = cyc;
      tick();
      arm = 1'b0;
      chk({tag, "_arm_state"}, state, (len == 0) ? 0 : 1);
      chk({tag, "_arm_ovf"}, overflow, 0);
      foreach (sq[i]) begin
         adc_data    = sq[i].d;
         adc_vld     = sq[i].v;
         fifo_wr_vld = sq[i].w;
         force_trig  = sq[i].f;
         dcyc.push_back(cyc);
         tick();
      end
      adc_vld     = 1'b0;
      force_trig  = 1'b0;
      fifo_wr_vld = 1'b1;
      tick();
      tick();
`ifdef CAPTURE_DECIM_EN
      dec_eff = dec;
`else
      dec_eff = 0;
`endif
      nv = 0;
      fi = -1;
      foreach (sq[i]) begin
         if (sq[i].f && fi < 0) fi = i;
         if (sq[i].v) begin
            if (nv % (dec_eff + 1) == 0) kidx.push_back(i);
            nv++;
         end
      end
      t = -1;
      if (len > 0) begin
         foreach (kidx[j]) begin
            if (t < 0) begin
               if (fi >= 0 && kidx[j] >= fi) t = j;
               else if (j > 0 && crossed(sq[kidx[j-1]].d, sq[kidx[j]].d, lvl, edg)) t = j;
            end
         end
      end
      exp_done = -1;
      exp_ovf  = 1'b0;
      exp_st   = (len == 0) ? 0 : 1;
      if (len == 0) begin
         exp_done = arm_cyc + 1;
      end else if (t >= 0) begin
         nf = (kidx.size() - t < len) ? kidx.size() - t : len;
         for (int m = 0; m < nf; m++) begin
            k = kidx[t + m];
            if (sq[k].w) begin
               ecyc.push_back(dcyc[k] + 1);
               edat.push_back((((m == 0) ? 1 : 0) << SOF_BIT) | int'(sq[k].d));
            end else begin
               exp_ovf = 1'b1;
            end
         end
         if (nf == len) begin
            exp_done = dcyc[kidx[t + len - 1]] + 1;
            exp_st   = 0;
         end else begin
            exp_st = 2;
         end
      end
      chk({tag, "_nwr"}, wr_cyc_q.size(), ecyc.size());
      foreach (ecyc[m]) begin
         if (m < wr_cyc_q.size()) begin
            chk($sformatf("%s_wr%0d_cyc", tag, m), wr_cyc_q[m], ecyc[m]);
            chk($sformatf("%s_wr%0d_dat", tag, m), wr_dat_q[m], edat[m]);
         end
      end
      chk({tag, "_ndone"}, done_q.size(), (exp_done >= 0) ? 1 : 0);
      if (exp_done >= 0 && done_q.size() > 0)
         chk({tag, "_done_cyc"}, done_q[0], exp_done);
      chk({tag, "_ovf"}, overflow, exp_ovf);
      chk({tag, "_state"}, state, exp_st);
      chk({tag, "_busy"}, busy, (exp_st != 0) ? 1 : 0);
      sq.delete();
   endtask

   int fpos;

   initial begin
      // reset values
      #3;
      chk("rst_wren", fifo_wr_en, 0);
      chk("rst_data", fifo_wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_state", state, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // rising ramp through 512
      for (int i = 0; i < 6; i++) push(500 + 10 * i, 1, 1, 0);
      run("rise", 4, 0, 512, 1'b0, 1'b0);

      // falling with equality triggers; rising with equality does not
      push(101, 1, 1, 0);
      push(100, 1, 1, 0);
      run("fall_eq", 1, 0, 100, 1'b1, 1'b0);
      push(100, 1, 1, 0);
      push(100, 1, 1, 0);
      run("rise_eq", 1, 0, 100, 1'b0, 1'b0);

      // decimation with forced trigger
      push(0, 0, 1, 1);
      for (int i = 0; i < 9; i++) push(10 * (i + 1), 1, 1, 0);
      run("decim", 3, 2, 1023, 1'b0, 1'b0);

      // backpressure on frame sample 3
      push(0, 0, 1, 1);
      for (int i = 1; i <= 6; i++) push(200 + i, 1, (i != 3), 0);
      run("bp", 5, 0, 1023, 1'b0, 1'b0);

      // partial frame with a drop, then re-arm during a sample
      push(0, 0, 1, 1);
      push(300, 1, 1, 0);
      push(301, 1, 0, 0);
      run("pre_rearm", 8, 0, 1023, 1'b0, 1'b0);
      push(0, 0, 1, 1);
      for (int i = 0; i < 4; i++) push(400 + i, 1, 1, 0);
      run("rearm", 3, 0, 1023, 1'b0, 1'b1);

      // zero-length frame
      push(0, 0, 1, 1);
      for (int i = 0; i < 5; i++) push(50 + i, 1, 1, 0);
      run("len0", 0, 0, 1023, 1'b0, 1'b0);

      // randomized frames
      for (int s = 0; s < 20; s++) begin
         fpos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 23)) : -1;
         for (int i = 0; i < 24; i++)
            push(int'($urandom_range(0, 1023)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) != 0), (i == fpos));
         run($sformatf("rnd%0d", s), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
             int'($urandom_range(200, 800)), 1'($urandom_range(0, 1)), 1'b0);
      end

      // async reset in the middle of a capture
      push(0, 0, 1, 1);
      push(60, 1, 1, 0);
      push(61, 1, 0, 0);
      push(62, 1, 1, 0);
      run("pre_rst", 10, 0, 1023, 1'b0, 1'b0);
      adc_data    = 10'd77;
      adc_vld     = 1'b1;
      fifo_wr_vld = 1'b1;
      tick();
      chk("mid_wren", fifo_wr_en, 1);
      chk("mid_data", fifo_wr_data, 77);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wren", fifo_wr_en, 0);
      chk("arst_data", fifo_wr_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_state", state, 0);
      adc_vld = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_state", state, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
